// File: rtl/branch_resolve_unit_if.sv
// Branch resolution bus between the ID stage and the branch resolve unit.
// The master drives the branch request and forwarding sources; the slave returns stall/result/statistics.
interface branch_resolve_unit_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OFF_W = 16,
   parameter int unsigned CNT_W = 16
);
   logic             br_valid;
   logic [2:0]       br_op;
   logic             opnd_ready;
   logic             kill;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic [1:0]       forwardAD;
   logic [1:0]       forwardBD;
   logic [WIDTH-1:0] alu_result_exmem;
   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] data_towrite_memwb;
   logic [WIDTH-1:0] pc_plus4;
   logic [OFF_W-1:0] offset;
   logic             stall_id;
   logic             res_valid;
   logic             branchtaken;
   logic             flush_if;
   logic [WIDTH-1:0] target_pc;
   logic             wait_timeout;
   logic [CNT_W-1:0] resolved_cnt;
   logic [CNT_W-1:0] taken_cnt;

   modport master (
      output br_valid, br_op, opnd_ready, kill, rs_data, rt_data, forwardAD, forwardBD,
             alu_result_exmem, data_out, data_towrite_memwb, pc_plus4, offset,
      input  stall_id, res_valid, branchtaken, flush_if, target_pc, wait_timeout,
             resolved_cnt, taken_cnt
   );

   modport slave (
      input  br_valid, br_op, opnd_ready, kill, rs_data, rt_data, forwardAD, forwardBD,
             alu_result_exmem, data_out, data_towrite_memwb, pc_plus4, offset,
      output stall_id, res_valid, branchtaken, flush_if, target_pc, wait_timeout,
             resolved_cnt, taken_cnt
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: forwarded operand select, full MIPS condition set,
// operand-wait stall with timeout flag, one-cycle registered result and statistics counters.
module branch_resolve_unit #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned OFF_W    = 16,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   branch_resolve_unit_if.slave bus
);
   localparam int unsigned WC_RAW = $clog2(MAX_WAIT + 1);
   localparam int unsigned WC_W   = (WC_RAW < 1) ? 1 : WC_RAW;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state_q, state_d;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [WIDTH-1:0]  opnd_a, opnd_b, off_sext, target_c;
   logic              taken_c, eval_c, stall_c, set_timeout_c;
   logic              res_valid_q, taken_q, timeout_q;
   logic [WIDTH-1:0]  target_q;
   logic [CNT_W-1:0]  resolved_q, taken_cnt_q;

   // Forwarding muxes for the two comparison operands
   always_comb begin
      case (bus.forwardAD)
         2'b00:   opnd_a = bus.rs_data;
         2'b01:   opnd_a = bus.alu_result_exmem;
         2'b10:   opnd_a = bus.data_out;
         default: opnd_a = bus.data_towrite_memwb;
      endcase
      case (bus.forwardBD)
         2'b00:   opnd_b = bus.rt_data;
         2'b01:   opnd_b = bus.alu_result_exmem;
         2'b10:   opnd_b = bus.data_out;
         default: opnd_b = bus.data_towrite_memwb;
      endcase
   end

   // Branch condition; zero-compare ops look only at operand a
   always_comb begin
      taken_c = 1'b0;
      case (bus.br_op)
         3'b000:  taken_c = (opnd_a == opnd_b);
         3'b001:  taken_c = (opnd_a != opnd_b);
         3'b010:  taken_c = opnd_a[WIDTH-1] | (opnd_a == '0);
         3'b011:  taken_c = ~opnd_a[WIDTH-1] & (opnd_a != '0);
         3'b100:  taken_c = opnd_a[WIDTH-1];
         3'b101:  taken_c = ~opnd_a[WIDTH-1];
         default: taken_c = 1'b0;
      endcase
   end

   assign off_sext = WIDTH'($signed(bus.offset));
   assign target_c = bus.pc_plus4 + (off_sext << 2);

   // Next-state: kill overrides everything, WAIT evaluates as soon as operands arrive
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      eval_c        = 1'b0;
      stall_c       = 1'b0;
      set_timeout_c = 1'b0;
      if (bus.kill) begin
         state_d    = IDLE;
         wait_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.br_valid) begin
                  if (bus.opnd_ready) begin
                     eval_c = 1'b1;
                  end else begin
                     state_d       = WAIT;
                     wait_cnt_d    = WC_W'(1);
                     stall_c       = 1'b1;
                     set_timeout_c = (WC_W'(1) == WC_W'(MAX_WAIT));
                  end
               end
            end
            WAIT: begin
               if (bus.opnd_ready) begin
                  eval_c     = 1'b1;
                  state_d    = IDLE;
                  wait_cnt_d = '0;
               end else begin
                  stall_c = 1'b1;
                  if (wait_cnt_q < WC_W'(MAX_WAIT)) begin
                     wait_cnt_d    = wait_cnt_q + WC_W'(1);
                     set_timeout_c = (wait_cnt_d == WC_W'(MAX_WAIT));
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         res_valid_q <= 1'b0;
         taken_q     <= 1'b0;
         target_q    <= '0;
         timeout_q   <= 1'b0;
         resolved_q  <= '0;
         taken_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         res_valid_q <= eval_c;
         taken_q     <= eval_c & taken_c;
         if (eval_c) begin
            target_q   <= target_c;
            resolved_q <= resolved_q + CNT_W'(1);
            if (taken_c) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
         end
         if (set_timeout_c) timeout_q <= 1'b1;
      end
   end

   // Stall is the only combinational output; forced low while reset is held
   assign bus.stall_id     = stall_c & ~rst;
   assign bus.res_valid    = res_valid_q;
   assign bus.branchtaken  = taken_q;
   assign bus.flush_if     = res_valid_q & taken_q;
   assign bus.target_pc    = target_q;
   assign bus.wait_timeout = timeout_q;
   assign bus.resolved_cnt = resolved_q;
   assign bus.taken_cnt    = taken_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected results are queued when a ready
// branch is driven and popped when res_valid is observed.
module tb_branch_resolve_unit;
   localparam int unsigned WIDTH    = 32;
   localparam int unsigned OFF_W    = 16;
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned MAX_WAIT = 3;

   logic clk = 1'b0;
   logic rst;

   branch_resolve_unit_if #(.WIDTH(WIDTH), .OFF_W(OFF_W), .CNT_W(CNT_W)) bus ();

   branch_resolve_unit #(.WIDTH(WIDTH), .OFF_W(OFF_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             taken;
      logic [WIDTH-1:0] target;
   } exp_t;

   typedef struct packed {
      logic [2:0]       op;
      logic [1:0]       fa;
      logic [1:0]       fb;
      logic [WIDTH-1:0] rs;
      logic [WIDTH-1:0] rt;
      logic [WIDTH-1:0] alu;
      logic [WIDTH-1:0] dout;
      logic [WIDTH-1:0] wb;
      logic [WIDTH-1:0] pc;
      logic [OFF_W-1:0] off;
   } vec_t;

   exp_t             sb[$];
   int               vectors     = 0;
   int               miscompares = 0;
   logic [CNT_W-1:0] exp_resolved = '0;
   logic [CNT_W-1:0] exp_taken    = '0;

   function automatic logic [WIDTH-1:0] pick(input logic [1:0] sel, input logic [WIDTH-1:0] reg_v,
                                             input logic [WIDTH-1:0] alu, dout, wb);
      if (sel == 2'd0) return reg_v;
      if (sel == 2'd1) return alu;
      if (sel == 2'd2) return dout;
      return wb;
   endfunction

   function automatic logic model_taken(input logic [2:0] op, input logic [WIDTH-1:0] a, b);
      int sa;
      sa = $signed(a);
      case (op)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd2:    return sa <= 0;
         3'd3:    return sa > 0;
         3'd4:    return sa < 0;
         3'd5:    return sa >= 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] model_target(input logic [WIDTH-1:0] pc, input logic [OFF_W-1:0] off);
      logic signed [WIDTH-1:0] s;
      s = {{(WIDTH-OFF_W){off[OFF_W-1]}}, off};
      return pc + WIDTH'(s * 4);
   endfunction

   // Drive one branch request; a ready request also queues its expected result
   task automatic drive_branch(input vec_t v, input logic ready);
      exp_t e;
      bus.br_valid           = 1'b1;
      bus.br_op              = v.op;
      bus.forwardAD          = v.fa;
      bus.forwardBD          = v.fb;
      bus.rs_data            = v.rs;
      bus.rt_data            = v.rt;
      bus.alu_result_exmem   = v.alu;
      bus.data_out           = v.dout;
      bus.data_towrite_memwb = v.wb;
      bus.pc_plus4           = v.pc;
      bus.offset             = v.off;
      bus.opnd_ready         = ready;
      if (ready && !bus.kill) begin
         e.taken  = model_taken(v.op, pick(v.fa, v.rs, v.alu, v.dout, v.wb), pick(v.fb, v.rt, v.alu, v.dout, v.wb));
         e.target = model_target(v.pc, v.off);
         sb.push_back(e);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.br_valid = 1'b0; bus.br_op = '0; bus.opnd_ready = 1'b0; bus.kill = 1'b0;
      bus.rs_data = '0; bus.rt_data = '0; bus.forwardAD = '0; bus.forwardBD = '0;
      bus.alu_result_exmem = '0; bus.data_out = '0; bus.data_towrite_memwb = '0;
      bus.pc_plus4 = '0; bus.offset = '0;
      #2;
      vectors++;
      if ({bus.stall_id, bus.res_valid, bus.branchtaken, bus.flush_if, bus.wait_timeout,
           bus.target_pc, bus.resolved_cnt, bus.taken_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset_state got st=%b rv=%b bt=%b fl=%b to=%b tgt=%h rc=%0d tc=%0d want all 0",
                  bus.stall_id, bus.res_valid, bus.branchtaken, bus.flush_if, bus.wait_timeout,
                  bus.target_pc, bus.resolved_cnt, bus.taken_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.res_valid, bus.stall_id} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_release got rv=%b st=%b want 0 0", bus.res_valid, bus.stall_id);
      end
   endtask

   task automatic test_beq_forward();
      exp_t e;
      @(negedge clk);
      drive_branch('{3'd0, 2'b01, 2'b00, 32'hDEAD_0000, 32'h1234, 32'h1234, 32'h0, 32'h0,
                     32'h100, 16'hFFFF}, 1'b1);
      @(negedge clk);
      bus.br_valid = 1'b0;
      vectors++;
      if (bus.res_valid !== 1'b1 || sb.size() == 0) begin
         miscompares++;
         $display("FAIL beq_fwd_valid got rv=%b want 1", bus.res_valid);
      end else begin
         e = sb.pop_front();
         exp_resolved++;
         if (e.taken) exp_taken++;
         vectors++;
         if ({bus.branchtaken, bus.flush_if, bus.target_pc} !== {e.taken, e.taken, e.target}) begin
            miscompares++;
            $display("FAIL beq_fwd_result got bt=%b fl=%b tgt=%h want bt=%b fl=%b tgt=%h",
                     bus.branchtaken, bus.flush_if, bus.target_pc, e.taken, e.taken, e.target);
         end
      end
      vectors++;
      if ({bus.target_pc, bus.taken_cnt, bus.resolved_cnt} !== {32'h0000_00FC, 16'd1, 16'd1}) begin
         miscompares++;
         $display("FAIL beq_fwd_abs got tgt=%h tc=%0d rc=%0d want tgt=000000fc tc=1 rc=1",
                  bus.target_pc, bus.taken_cnt, bus.resolved_cnt);
      end
   endtask

   task automatic test_conditions();
      vec_t tbl [0:10];
      exp_t e;
      tbl[0]  = '{3'd3, 2'd0, 2'd0, 32'h8000_0000, 32'h0, 32'h1, 32'h1, 32'h1, 32'h200, 16'h0010};
      tbl[1]  = '{3'd4, 2'd0, 2'd0, 32'h8000_0000, 32'h0, 32'h1, 32'h1, 32'h1, 32'h200, 16'h0001};
      tbl[2]  = '{3'd2, 2'd0, 2'd0, 32'h0, 32'hFFFF, 32'h5, 32'h5, 32'h5, 32'h300, 16'hFFFE};
      tbl[3]  = '{3'd5, 2'd0, 2'd0, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h5, 32'h5, 32'hFFFF_FFF0, 16'h0010};
      tbl[4]  = '{3'd3, 2'd3, 2'd0, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 16'h7FFF};
      tbl[5]  = '{3'd2, 2'd2, 2'd0, 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'h0, 32'h400, 16'h0004};
      tbl[6]  = '{3'd0, 2'd1, 2'd3, 32'h6, 32'h6, 32'h5, 32'h0, 32'h6, 32'h500, 16'h0008};
      tbl[7]  = '{3'd1, 2'd0, 2'd2, 32'h7, 32'h8, 32'h0, 32'h7, 32'h0, 32'h600, 16'h8000};
      tbl[8]  = '{3'd0, 2'd3, 2'd1, 32'h0, 32'h1, 32'h9, 32'h0, 32'h9, 32'h700, 16'h0002};
      tbl[9]  = '{3'd4, 2'd1, 2'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h800, 16'h0003};
      tbl[10] = '{3'd7, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h900, 16'h0001};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         drive_branch(tbl[i], 1'b1);
         @(negedge clk);
         bus.br_valid = 1'b0;
         vectors++;
         if (bus.res_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL cond[%0d]_valid got rv=%b want 1", i, bus.res_valid);
         end else begin
            e = sb.pop_front();
            exp_resolved++;
            if (e.taken) exp_taken++;
            vectors++;
            if ({bus.branchtaken, bus.flush_if, bus.target_pc, bus.resolved_cnt, bus.taken_cnt} !==
                {e.taken, e.taken, e.target, exp_resolved, exp_taken}) begin
               miscompares++;
               $display("FAIL cond[%0d] got bt=%b fl=%b tgt=%h rc=%0d tc=%0d want bt=%b tgt=%h rc=%0d tc=%0d",
                        i, bus.branchtaken, bus.flush_if, bus.target_pc, bus.resolved_cnt, bus.taken_cnt,
                        e.taken, e.target, exp_resolved, exp_taken);
            end
         end
         @(negedge clk);
         vectors++;
         if ({bus.res_valid, bus.branchtaken, bus.flush_if} !== 3'b000) begin
            miscompares++;
            $display("FAIL cond[%0d]_pulse got rv=%b bt=%b fl=%b want 0 0 0",
                     i, bus.res_valid, bus.branchtaken, bus.flush_if);
         end
      end
   endtask

   task automatic test_load_use();
      vec_t v;
      exp_t e;
      v = '{3'd0, 2'b10, 2'b00, 32'h0, 32'h55, 32'h0, 32'h55, 32'h0, 32'h1000, 16'h0040};
      @(negedge clk);
      drive_branch(v, 1'b0);
      #1;
      vectors++;
      if (bus.stall_id !== 1'b1) begin
         miscompares++;
         $display("FAIL load_use_stall1 got %b want 1", bus.stall_id);
      end
      @(negedge clk);
      vectors++;
      if ({bus.stall_id, bus.res_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL load_use_stall2 got st=%b rv=%b want 1 0", bus.stall_id, bus.res_valid);
      end
      @(negedge clk);
      drive_branch(v, 1'b1);
      #1;
      vectors++;
      if (bus.stall_id !== 1'b0) begin
         miscompares++;
         $display("FAIL load_use_release got st=%b want 0", bus.stall_id);
      end
      @(negedge clk);
      bus.br_valid = 1'b0;
      vectors++;
      if (bus.res_valid !== 1'b1 || sb.size() == 0) begin
         miscompares++;
         $display("FAIL load_use_valid got rv=%b want 1", bus.res_valid);
      end else begin
         e = sb.pop_front();
         exp_resolved++;
         if (e.taken) exp_taken++;
         vectors++;
         if ({bus.branchtaken, bus.target_pc, bus.wait_timeout} !== {e.taken, e.target, 1'b0}) begin
            miscompares++;
            $display("FAIL load_use_result got bt=%b tgt=%h to=%b want bt=%b tgt=%h to=0",
                     bus.branchtaken, bus.target_pc, bus.wait_timeout, e.taken, e.target);
         end
      end
   endtask

   task automatic test_timeout_kill();
      vec_t v;
      logic exp_to;
      v = '{3'd1, 2'b00, 2'b00, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0, 32'h2000, 16'h0004};
      @(negedge clk);
      drive_branch(v, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         exp_to = (c >= int'(MAX_WAIT));
         vectors++;
         if ({bus.stall_id, bus.res_valid, bus.wait_timeout} !== {1'b1, 1'b0, exp_to}) begin
            miscompares++;
            $display("FAIL timeout_cyc%0d got st=%b rv=%b to=%b want st=1 rv=0 to=%b",
                     c, bus.stall_id, bus.res_valid, bus.wait_timeout, exp_to);
         end
      end
      bus.kill = 1'b1;
      bus.opnd_ready = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      bus.br_valid = 1'b0;
      vectors++;
      if ({bus.res_valid, bus.resolved_cnt, bus.wait_timeout} !== {1'b0, exp_resolved, 1'b1}) begin
         miscompares++;
         $display("FAIL kill_result got rv=%b rc=%0d to=%b want rv=0 rc=%0d to=1",
                  bus.res_valid, bus.resolved_cnt, bus.wait_timeout, exp_resolved);
      end
      @(negedge clk);
      vectors++;
      if ({bus.res_valid, bus.stall_id, bus.wait_timeout} !== 3'b001) begin
         miscompares++;
         $display("FAIL kill_idle got rv=%b st=%b to=%b want 0 0 1", bus.res_valid, bus.stall_id, bus.wait_timeout);
      end
   endtask

   task automatic test_reset_mid_wait();
      vec_t v;
      v = '{3'd0, 2'b00, 2'b00, 32'h3, 32'h3, 32'h0, 32'h0, 32'h0, 32'h3000, 16'h0004};
      @(negedge clk);
      drive_branch(v, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({bus.stall_id, bus.res_valid, bus.branchtaken, bus.flush_if, bus.wait_timeout,
           bus.target_pc, bus.resolved_cnt, bus.taken_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_wait got st=%b rv=%b to=%b tgt=%h rc=%0d tc=%0d want all 0",
                  bus.stall_id, bus.res_valid, bus.wait_timeout, bus.target_pc, bus.resolved_cnt, bus.taken_cnt);
      end
      bus.br_valid = 1'b0;
      bus.opnd_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_resolved = '0;
      exp_taken = '0;
      @(negedge clk);
      vectors++;
      if ({bus.res_valid, bus.stall_id} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_mid_wait_idle got rv=%b st=%b want 0 0", bus.res_valid, bus.stall_id);
      end
   endtask

   task automatic test_back_to_back();
      vec_t v0, v1;
      exp_t e;
      logic [WIDTH-1:0] last_tgt;
      v0 = '{3'd1, 2'b00, 2'b00, 32'hA, 32'hB, 32'h0, 32'h0, 32'h0, 32'h4000, 16'h0010};
      v1 = '{3'd6, 2'b00, 2'b00, 32'hA, 32'hB, 32'h0, 32'h0, 32'h0, 32'h4004, 16'hFFF0};
      @(negedge clk);
      drive_branch(v0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (k == 0) drive_branch(v1, 1'b1);
         else bus.br_valid = 1'b0;
         vectors++;
         if (bus.res_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL b2b[%0d]_valid got rv=%b want 1", k, bus.res_valid);
         end else begin
            e = sb.pop_front();
            exp_resolved++;
            if (e.taken) exp_taken++;
            vectors++;
            if ({bus.branchtaken, bus.flush_if, bus.target_pc, bus.resolved_cnt} !==
                {e.taken, e.taken, e.target, exp_resolved}) begin
               miscompares++;
               $display("FAIL b2b[%0d] got bt=%b fl=%b tgt=%h rc=%0d want bt=%b tgt=%h rc=%0d",
                        k, bus.branchtaken, bus.flush_if, bus.target_pc, bus.resolved_cnt,
                        e.taken, e.target, exp_resolved);
            end
         end
      end
      last_tgt = model_target(v1.pc, v1.off);
      @(negedge clk);
      vectors++;
      if ({bus.res_valid, bus.branchtaken, bus.flush_if, bus.target_pc, bus.resolved_cnt, bus.taken_cnt} !==
          {3'b000, last_tgt, 16'd2, 16'd1}) begin
         miscompares++;
         $display("FAIL b2b_end got rv=%b bt=%b tgt=%h rc=%0d tc=%0d want rv=0 bt=0 tgt=%h rc=2 tc=1",
                  bus.res_valid, bus.branchtaken, bus.target_pc, bus.resolved_cnt, bus.taken_cnt, last_tgt);
      end
   endtask

   initial begin
      test_reset();
      test_beq_forward();
      test_conditions();
      test_load_use();
      test_timeout_kill();
      test_reset_mid_wait();
      test_back_to_back();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
